// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the pipeline/LSU/UART side (master) and the register file write arbiter (slave).
// With REGFILE_ARB_PERF_EN defined the bundle also carries perf_conflicts.
interface regfile_write_arbiter_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int BUF_DEPTH = 2
);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  // valid/ready: an LSU transfer happens on a posedge where lsu_valid && lsu_ready;
  // a debug transfer where dbg_valid && dbg_ready; wb_valid is always taken.
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_data;
  logic              dbg_valid;
  logic              dbg_ready;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [ADDR_W-1:0] chk_addr;
  logic              chk_hit;
  logic              stall_req;
  logic              rf_write_en;
  logic [ADDR_W-1:0] rf_write_register;
  logic [DATA_W-1:0] rf_data_write;
  logic [CNT_W-1:0]  pend_count;
`ifdef REGFILE_ARB_PERF_EN
  logic [15:0]       perf_conflicts;
`endif

  modport master (
`ifdef REGFILE_ARB_PERF_EN
    input  perf_conflicts,
`endif
    output wb_valid, wb_addr, wb_data,
    output lsu_valid, lsu_addr, lsu_data,
    output dbg_valid, dbg_addr, dbg_data,
    output chk_addr,
    input  lsu_ready, dbg_ready, chk_hit, stall_req,
    input  rf_write_en, rf_write_register, rf_data_write, pend_count
  );

  modport slave (
`ifdef REGFILE_ARB_PERF_EN
    output perf_conflicts,
`endif
    input  wb_valid, wb_addr, wb_data,
    input  lsu_valid, lsu_addr, lsu_data,
    input  dbg_valid, dbg_addr, dbg_data,
    input  chk_addr,
    output lsu_ready, dbg_ready, chk_hit, stall_req,
    output rf_write_en, rf_write_register, rf_data_write, pend_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Single write-port scheduler for the register file: WB > LSU FIFO head > debug, with WB-kills-older-load ordering.
// Define REGFILE_ARB_PERF_EN to add the saturating perf_conflicts counter.
module regfile_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                   clock,
  input logic                   reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0]    addr_q [BUF_DEPTH];
  logic [DATA_W-1:0]    data_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [STV_W-1:0]     starve_q, starve_d;
  logic                 stall_q, stall_d;
  logic                 rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]    rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]    rf_data_q, rf_data_d;

  logic              fifo_empty, h0_killed, cand_present, cand_valid;
  logic              lsu_go, dbg_go, push, push_live, lose, grant, hit;
  logic [PTR_W-1:0]  head1, cand_idx;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;

  // A killed head retires for free, so the entry behind it becomes the grant candidate.
  always_comb begin
    fifo_empty   = (count_q == '0);
    head1        = rd_ptr_q + PTR_W'(1);
    h0_killed    = !fifo_empty && !vld_q[rd_ptr_q];
    cand_idx     = h0_killed ? head1 : rd_ptr_q;
    cand_present = h0_killed ? (count_q >= CNT_W'(2)) : !fifo_empty;
    cand_valid   = cand_present && vld_q[cand_idx];
    lsu_go       = !bus.wb_valid && cand_valid;
    dbg_go       = !bus.wb_valid && fifo_empty && bus.dbg_valid;
    push         = bus.lsu_valid && bus.lsu_ready;
    push_live    = (bus.lsu_addr != '0) && !(bus.wb_valid && (bus.lsu_addr == bus.wb_addr));
    lose         = bus.wb_valid && cand_valid && (addr_q[cand_idx] != bus.wb_addr);
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == bus.chk_addr)) hit = 1'b1;
    end
  end

  assign bus.chk_hit   = hit && (bus.chk_addr != '0);
  assign bus.lsu_ready = (count_q < CNT_W'(BUF_DEPTH));
  assign bus.dbg_ready = !bus.wb_valid && fifo_empty;

  always_comb begin
    grant  = 1'b0;
    g_addr = '0;
    g_data = '0;
    if (bus.wb_valid) begin
      grant  = 1'b1;
      g_addr = bus.wb_addr;
      g_data = bus.wb_data;
    end else if (lsu_go) begin
      grant  = 1'b1;
      g_addr = addr_q[cand_idx];
      g_data = data_q[cand_idx];
    end else if (dbg_go) begin
      grant  = 1'b1;
      g_addr = bus.dbg_addr;
      g_data = bus.dbg_data;
    end

    // x0 is consumed like any other grant but never reaches the register file.
    rf_we_d   = grant && (g_addr != '0);
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (rf_we_d) begin
      rf_addr_d = g_addr;
      rf_data_d = g_data;
    end

    // WB to a pending destination kills the older load so it cannot clobber the newer value.
    vld_d = vld_q;
    if (bus.wb_valid) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (addr_q[i] == bus.wb_addr) vld_d[i] = 1'b0;
      end
    end
    if (lsu_go) vld_d[cand_idx] = 1'b0;
    if (push)   vld_d[wr_ptr_q] = push_live;

    rd_ptr_d = rd_ptr_q + PTR_W'(h0_killed) + PTR_W'(lsu_go);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d  = count_q + CNT_W'(push) - CNT_W'(h0_killed) - CNT_W'(lsu_go);

    starve_d = starve_q;
    if (lsu_go || fifo_empty) starve_d = '0;
    else if (lose && (starve_q != STV_W'(STARVE_LIMIT))) starve_d = starve_q + STV_W'(1);
    stall_d = (starve_d == STV_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      vld_q     <= vld_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Payload storage needs no reset: occupancy and valid bits gate every use.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.lsu_addr;
      data_q[wr_ptr_q] <= bus.lsu_data;
    end
  end

  assign bus.stall_req         = stall_q;
  assign bus.rf_write_en       = rf_we_q;
  assign bus.rf_write_register = rf_addr_q;
  assign bus.rf_data_write     = rf_data_q;
  assign bus.pend_count        = count_q;

`ifdef REGFILE_ARB_PERF_EN
  logic [15:0] perf_q;
  logic        conflict;

  assign conflict = (bus.wb_valid && cand_valid) || (bus.wb_valid && bus.dbg_valid) ||
                    (cand_valid && bus.dbg_valid);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                perf_q <= '0;
    else if (conflict && (perf_q != 16'hFFFF)) perf_q <= perf_q + 16'd1;
  end

  assign bus.perf_conflicts = perf_q;
`endif
endmodule
